// File: rtl/mesi_protocol.sv
// Single-line MESI coherence controller: tracks the I/S/E/M state of one cache line
// and emits a registered one-cycle pulse whenever an event requires bus activity.
module mesi_protocol (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] inbits,
  input  logic       r_w,
  output logic       detect,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_I = 2'b00,
    ST_S = 2'b01,
    ST_E = 2'b10,
    ST_M = 2'b11
  } mesi_state_e;

  typedef enum logic [1:0] {
    EV_IDLE        = 2'b00,
    EV_LOCAL_NOSHR = 2'b01,
    EV_SNOOP       = 2'b10,
    EV_LOCAL_SHR   = 2'b11
  } event_e;

  mesi_state_e state_q;
  mesi_state_e state_d;
  logic        detect_d;
  event_e      ev;

  assign ev    = event_e'(inbits);
  assign state = state_q;

  always_comb begin
    // NOTE: defaults first so every path assigns both signals; a missed branch would infer a latch.
    state_d  = state_q;
    detect_d = 1'b0;
    case (state_q)
      ST_I: begin
        case (ev)
          EV_LOCAL_NOSHR, EV_LOCAL_SHR: begin
            detect_d = 1'b1;
            if (r_w)                     state_d = ST_M;
            else if (ev == EV_LOCAL_SHR) state_d = ST_S;
            else                         state_d = ST_E;
          end
          default: ;
        endcase
      end
      ST_S: begin
        case (ev)
          EV_LOCAL_NOSHR, EV_LOCAL_SHR: begin
            if (r_w) begin
              state_d  = ST_M;
              detect_d = 1'b1;
            end
          end
          EV_SNOOP: begin
            if (r_w) state_d = ST_I;
          end
          default: ;
        endcase
      end
      ST_E: begin
        case (ev)
          // Exclusive ownership means a local write upgrades without telling the bus.
          EV_LOCAL_NOSHR, EV_LOCAL_SHR: begin
            if (r_w) state_d = ST_M;
          end
          EV_SNOOP: state_d = r_w ? ST_I : ST_S;
          default: ;
        endcase
      end
      ST_M: begin
        case (ev)
          EV_SNOOP: begin
            detect_d = 1'b1;
            state_d  = r_w ? ST_I : ST_S;
          end
          default: ;
        endcase
      end
      // Unknown register contents fall back to Invalid, the only safe assumption.
      default: state_d = ST_I;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (reset) begin
      state_q <= ST_I;
      detect  <= 1'b0;
    end else begin
      state_q <= state_d;
      detect  <= detect_d;
    end
  end

endmodule

// File: tb/tb_mesi_protocol.sv
// Directed and randomized bench for mesi_protocol, checked against a line model
// expressed as valid/exclusive/dirty ownership flags.
module tb_mesi_protocol;

  logic       clk_tb;
  logic       reset;
  logic [1:0] inbits;
  logic       r_w;
  logic       detect;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  logic m_valid, m_excl, m_dirty, m_detect;

  mesi_protocol dut (
    .clk    (clk_tb),
    .reset  (reset),
    .inbits (inbits),
    .r_w    (r_w),
    .detect (detect),
    .state  (state)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  function automatic logic [1:0] model_state();
    if (!m_valid)     return 2'b00;
    else if (m_dirty) return 2'b11;
    else if (m_excl)  return 2'b10;
    else              return 2'b01;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_excl   = 1'b0;
    m_dirty  = 1'b0;
    m_detect = 1'b0;
  endtask

  // Bus action is needed to fetch a missing line, to gain ownership we lack,
  // or to flush dirty data another agent wants.
  task automatic model_step(input logic [1:0] ib, input logic rw);
    m_detect = 1'b0;
    case (ib)
      2'b01, 2'b11: begin
        if (!rw) begin
          if (!m_valid) begin
            m_detect = 1'b1;
            m_valid  = 1'b1;
            m_excl   = (ib == 2'b01);
            m_dirty  = 1'b0;
          end
        end else begin
          m_detect = !(m_valid && m_excl);
          m_valid  = 1'b1;
          m_excl   = 1'b1;
          m_dirty  = 1'b1;
        end
      end
      2'b10: begin
        if (m_valid) begin
          m_detect = m_dirty;
          m_dirty  = 1'b0;
          m_excl   = 1'b0;
          if (rw) m_valid = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check(input string tag);
    logic [1:0] exp_state;
    exp_state = model_state();
    n_checks++;
    assert (state === exp_state) else begin
      n_errors++;
      $error("FAIL %s state: got %b expected %b", tag, state, exp_state);
    end
    n_checks++;
    assert (detect === m_detect) else begin
      n_errors++;
      $error("FAIL %s detect: got %b expected %b", tag, detect, m_detect);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next.
  task automatic apply(input logic [1:0] ib, input logic rw, input string tag);
    inbits = ib;
    r_w    = rw;
    @(posedge clk_tb);
    model_step(ib, rw);
    #1;
    check(tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check(tag);
    @(posedge clk_tb);
    #1;
    check({tag, "_held"});
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    inbits = 2'b11;
    r_w    = 1'b0;
    model_reset();
    #1;
    check("reset_async");
    @(posedge clk_tb);
    #1;
    check("reset_held");
    reset = 1'b0;

    apply(2'b11, 1'b0, "i_to_s_fill");
    apply(2'b01, 1'b1, "s_to_m_inval");
    apply(2'b00, 1'b0, "m_idle");

    pulse_reset("rst_b");
    apply(2'b01, 1'b0, "i_to_e_fill");
    apply(2'b01, 1'b1, "e_to_m_silent");
    apply(2'b10, 1'b0, "m_snoop_rd_wb");
    apply(2'b10, 1'b1, "s_snoop_wr");

    apply(2'b01, 1'b1, "i_to_m_rfo");
    apply(2'b10, 1'b1, "m_snoop_wr_wb");
    apply(2'b10, 1'b0, "i_snoop_rd");

    pulse_reset("rst_c");
    apply(2'b11, 1'b0, "alt0_rd");
    apply(2'b01, 1'b1, "alt1_wr");
    apply(2'b11, 1'b0, "alt2_rd");
    apply(2'b01, 1'b1, "alt3_wr");
    apply(2'b11, 1'b0, "alt4_rd");
    pulse_reset("rst_mid");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        inbits = 2'($urandom_range(0, 3));
        r_w    = 1'($urandom_range(0, 1));
        pulse_reset("rand_rst");
      end else begin
        apply(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mesi_protocol.md
Name: mesi_protocol

Overview:
Single-cache-line MESI coherence controller. Each cycle it samples one event: idle, a local processor access, or a snooped bus transaction. It tracks the line state (I/S/E/M) and emits a one-cycle `detect` pulse whenever the event requires bus activity (miss fill, invalidate/RFO, or dirty writeback). It sits between the cache line tag/state store and the bus interface logic.

Parameters:
- ST_I, 2'b00, encoding of Invalid
- ST_S, 2'b01, encoding of Shared
- ST_E, 2'b10, encoding of Exclusive
- ST_M, 2'b11, encoding of Modified

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- inbits  input  2  event code (see Behaviour)
- r_w  input  1  access/snoop type: 0 = read, 1 = write
- detect  output  1  registered one-cycle bus-action pulse
- state  output  2  current MESI state (registered; observability)

Behaviour:
- Reset (async, active-high): state <= ST_I, detect <= 0 immediately. Both are held while reset is high. The first update happens on the first rising clk after deassertion.
- inbits decode:
  - 00 = idle.
  - 01 = local access, bus SHARED line low (no other holder).
  - 11 = local access, SHARED line high.
  - 10 = snoop; r_w=0 is a bus read, r_w=1 is a bus write/RFO.
- r_w is ignored when inbits=00.
- All inputs are sampled on the rising clk. `state` and `detect` update on that same edge, so the result is visible one cycle after the inputs are applied.
- Local read (inbits 01/11, r_w=0):
  - I->E if SHARED low, I->S if SHARED high. Both set detect=1 (miss fill).
  - S, E, M hold; detect=0.
- Local write (inbits 01/11, r_w=1), SHARED ignored:
  - I->M, detect=1 (RFO).
  - S->M, detect=1 (invalidate broadcast).
  - E->M, detect=0 (silent upgrade).
  - M->M, detect=0.
- Snoop read (inbits 10, r_w=0):
  - M->S, detect=1 (writeback).
  - E->S, detect=0.
  - S and I hold; detect=0.
- Snoop write (inbits 10, r_w=1):
  - M->I, detect=1 (writeback).
  - E->I, detect=0.
  - S->I, detect=0.
  - I holds; detect=0.
- Idle: state holds, detect=0.
- detect is high for exactly the cycle after a qualifying event. Back-to-back qualifying events keep detect high on consecutive cycles.
- Illegal/unknown state register value: recover to ST_I on the next clock, detect=0.
- Reset asserted mid-sequence aborts the pending update. state=I and detect=0 regardless of inputs.
- Combinational next-state/next-detect logic; exactly one state register and one detect register.

Test Plan:
- Assert reset with inbits=11, r_w=0, then release. Expect state=00 and detect=0 throughout reset. First edge after release: state=01 (I->S), detect=1.
- From S, apply inbits=01, r_w=1 for one cycle. Expect state=11 (S->M), detect=1. Then apply idle. Expect state=11, detect=0.
- From I, apply inbits=01, r_w=0. Expect state=10 (E), detect=1. Next apply inbits=01, r_w=1. Expect state=11, detect=0 (silent upgrade).
- From M, apply inbits=10, r_w=0. Expect state=01, detect=1. Next apply inbits=10, r_w=1. Expect state=00, detect=0.
- From M, apply inbits=10, r_w=1. Expect state=00, detect=1. From I, apply a snoop read. Expect state stays 00, detect=0.
- Alternate local read (inbits 11) and write (inbits 01) for 5 cycles from reset. Expect state sequence S, M, M, M, M and detect sequence 1, 1, 0, 0, 0. Assert reset asynchronously mid-cycle: state=00 and detect=0 immediately.
